// File: rtl/msi_line_controller.sv
// MSI snooping coherence controller for a direct-mapped cache of 2**INDEX_W lines.
// Define MSI_EXCLUSIVE_EN to add the E state (MESI) and the snoop_shared_in input.
module msi_line_controller #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cpu_valid,
    input  logic                     cpu_write,
    input  logic [INDEX_W-1:0]       cpu_index,
    input  logic [TAG_W-1:0]         cpu_tag,
    output logic                     cpu_ready,
    output logic                     cpu_done,
    output logic                     cpu_hit,
    output logic                     bus_read_miss,
    output logic                     bus_write_miss,
    output logic                     bus_invalidate,
    output logic                     bus_write_back,
    output logic [TAG_W+INDEX_W-1:0] bus_addr,
    input  logic                     bus_grant,
    input  logic [1:0]               snoop_op,
    input  logic [INDEX_W-1:0]       snoop_index,
    input  logic [TAG_W-1:0]         snoop_tag,
    output logic                     snoop_write_back,
    output logic                     snoop_abort_mem,
    output logic                     snoop_shared,
`ifdef MSI_EXCLUSIVE_EN
    input  logic                     snoop_shared_in,
`endif
    output logic [1:0]               line_state
);

    localparam int N = 2**INDEX_W;

    typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10, ST_E = 2'b11} line_t;
    typedef enum logic [2:0] {FSM_IDLE, FSM_WB, FSM_MISS, FSM_INV, FSM_DONE} fsm_t;

    localparam logic [1:0] SNP_NONE = 2'b00;
    localparam logic [1:0] SNP_READ = 2'b01;

    fsm_t               r_fsm, w_fsm_next;
    line_t              r_state [N];
    logic [TAG_W-1:0]   r_tag   [N];
    line_t              w_snp_state [N];

    logic               r_req_write;
    logic [INDEX_W-1:0] r_req_index;
    logic [TAG_W-1:0]   r_req_tag;
    logic               r_hit;
    logic               r_snoop_wb;
    logic               r_snoop_shared;

    logic               w_accept;
    logic               w_snoop_hit;
    line_t              w_lookup_state;
    logic               w_lookup_hit;
    line_t              w_cur_state;
    line_t              w_fill_state;
    logic               w_upd_en;
    logic [INDEX_W-1:0] w_upd_index;
    line_t              w_upd_state;
    logic               w_upd_tag_en;
    logic [TAG_W-1:0]   w_upd_tag;

    assign w_accept       = cpu_valid && cpu_ready;
    assign w_lookup_state = r_state[cpu_index];
    assign w_lookup_hit   = (w_lookup_state != ST_I) && (r_tag[cpu_index] == cpu_tag);
    assign w_snoop_hit    = (snoop_op != SNP_NONE) && (r_state[snoop_index] != ST_I)
                            && (r_tag[snoop_index] == snoop_tag);

    // Snooped traffic is resolved first; the FSM then sees the post-snoop line state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        for (int i = 0; i < N; i++) w_snp_state[i] = r_state[i];
        if (w_snoop_hit) w_snp_state[snoop_index] = (snoop_op == SNP_READ) ? ST_S : ST_I;
    end

    assign w_cur_state = w_snp_state[r_req_index];

`ifdef MSI_EXCLUSIVE_EN
    assign w_fill_state = r_req_write ? ST_M : (snoop_shared_in ? ST_S : ST_E);
`else
    assign w_fill_state = r_req_write ? ST_M : ST_S;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= FSM_IDLE;
            r_hit <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_fsm <= w_fsm_next;
            if (r_fsm == FSM_IDLE) r_hit <= (w_fsm_next == FSM_DONE);
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_upd_en     = 1'b0;
        w_upd_index  = r_req_index;
        w_upd_state  = w_cur_state;
        w_upd_tag_en = 1'b0;
        w_upd_tag    = r_req_tag;
        case (r_fsm)
            FSM_IDLE: begin
                if (w_accept) begin
                    if (w_lookup_hit && !cpu_write) begin
                        w_fsm_next = FSM_DONE;
                    end else if (w_lookup_hit) begin
                        if (w_lookup_state == ST_S) begin
                            w_fsm_next = FSM_INV;
                        end else begin
                            w_fsm_next = FSM_DONE;
                            if (w_lookup_state == ST_E) begin
                                w_upd_en    = 1'b1;
                                w_upd_index = cpu_index;
                                w_upd_state = ST_M;
                            end
                        end
                    end else if (w_lookup_state == ST_M) begin
                        w_fsm_next = FSM_WB;
                    end else begin
                        w_fsm_next = FSM_MISS;
                    end
                end
            end
            FSM_WB: begin
                if (bus_grant) begin
                    w_upd_en    = 1'b1;
                    w_upd_state = ST_I;
                    w_fsm_next  = FSM_MISS;
                end else if (w_cur_state != ST_M) begin
                    w_fsm_next = FSM_MISS;
                end
            end
            FSM_INV: begin
                // A snoop that kills the shared copy turns the upgrade into a write miss.
                if (w_cur_state == ST_I) begin
                    w_fsm_next = FSM_MISS;
                end else if (bus_grant) begin
                    w_upd_en    = 1'b1;
                    w_upd_state = ST_M;
                    w_fsm_next  = FSM_DONE;
                end
            end
            FSM_MISS: begin
                if (bus_grant) begin
                    w_upd_en     = 1'b1;
                    w_upd_state  = w_fill_state;
                    w_upd_tag_en = 1'b1;
                    w_fsm_next   = FSM_DONE;
                end
            end
            FSM_DONE: w_fsm_next = FSM_IDLE;
            default:  w_fsm_next = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the line array is small and must start invalid, so it is reset like any register.
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_I;
                r_tag[i]   <= '0;
            end
            r_req_write    <= 1'b0;
            r_req_index    <= '0;
            r_req_tag      <= '0;
            r_snoop_wb     <= 1'b0;
            r_snoop_shared <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_upd_en && (w_upd_index == INDEX_W'(i))) r_state[i] <= w_upd_state;
                else                                          r_state[i] <= w_snp_state[i];
                if (w_upd_tag_en && (w_upd_index == INDEX_W'(i))) r_tag[i] <= w_upd_tag;
            end
            if (w_accept) begin
                r_req_write <= cpu_write;
                r_req_index <= cpu_index;
                r_req_tag   <= cpu_tag;
            end
            r_snoop_wb     <= w_snoop_hit && (r_state[snoop_index] == ST_M);
            r_snoop_shared <= w_snoop_hit;
        end
    end

    always_comb begin
        cpu_ready      = (r_fsm == FSM_IDLE) && !((snoop_op != SNP_NONE) && (snoop_index == cpu_index));
        cpu_done       = (r_fsm == FSM_DONE);
        cpu_hit        = (r_fsm == FSM_DONE) && r_hit;
        bus_write_back = (r_fsm == FSM_WB) && (r_state[r_req_index] == ST_M);
        bus_read_miss  = (r_fsm == FSM_MISS) && !r_req_write;
        bus_write_miss = (r_fsm == FSM_MISS) && r_req_write;
        bus_invalidate = (r_fsm == FSM_INV);
        bus_addr       = '0;
        if (r_fsm == FSM_WB)
            bus_addr = {r_tag[r_req_index], r_req_index};
        else if ((r_fsm == FSM_MISS) || (r_fsm == FSM_INV))
            bus_addr = {r_req_tag, r_req_index};
        line_state     = r_state[cpu_index];
    end

    assign snoop_write_back = r_snoop_wb;
    assign snoop_abort_mem  = r_snoop_wb;
    assign snoop_shared     = r_snoop_shared;

endmodule
